signed_div_32bit: RTL and testbench



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/signed_div_32bit.sv | 190 +++++++++++++++++++
 tb/tb_signed_div_32bit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor magnitude.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;

    // The shifted value needs WIDTH+1 bits; whatever survives the subtraction is below the divisor and fits in WIDTH.
    always_comb begin
        shifted_s = {rem, next_bit};
        diff_s    = shifted_s[WIDTH-1:0] - dvs_mag;
        if (shifted_s >= {1'b0, dvs_mag}) begin
            q_bit    = 1'b1;
            rem_next = diff_s;
        end else begin
            q_bit    = 1'b0;
            rem_next = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/signed_div_32bit.sv
// Sequential signed divider, one quotient bit per clock, valid/ready on both sides.
// Optional build macro DIV_UNSIGNED_MODE_EN adds the is_signed port for unsigned operation.
module signed_div_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DIV_UNSIGNED_MODE_EN
    input  logic             is_signed,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_e       state_r;
    div_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic             sign_q_r;
    logic             sign_r_r;

    logic             signed_op_s;
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic             dvs_zero_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_bit_s;
    logic             accept_s;
    logic             step_s;
    logic             fix_s;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;

    // Two's-complement negate when requested; the most negative value wraps to itself as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = {WIDTH{1'b0}} - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

`ifdef DIV_UNSIGNED_MODE_EN
    assign signed_op_s = is_signed;
`else
    assign signed_op_s = 1'b1;
`endif

    assign dvd_neg_s  = signed_op_s & dividend[WIDTH-1];
    assign dvs_neg_s  = signed_op_s & divisor[WIDTH-1];
    assign dvs_zero_s = (divisor == {WIDTH{1'b0}});

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .next_bit (dvd_r[WIDTH-1]),
        .dvs_mag  (dvs_r),
        .rem_next (step_rem_s),
        .q_bit    (step_bit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = dvs_zero_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath strobes and next values of the handshake flags.
    always_comb begin
        accept_s        = 1'b0;
        step_s          = 1'b0;
        fix_s           = 1'b0;
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        out_valid_nxt_s = (state_nxt_s == DONE);
        case (state_r)
            IDLE:    accept_s = in_valid;
            CALC:    step_s   = 1'b1;
            FIX:     fix_s    = 1'b1;
            DONE:    accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt_s;
            out_valid <= out_valid_nxt_s;
        end
    end

    // Working registers: operand magnitudes, partial remainder and quotient shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= CNT_TOP;
            dvd_r    <= cond_neg(dividend, dvd_neg_s);
            dvs_r    <= cond_neg(divisor, dvs_neg_s);
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            sign_q_r <= dvd_neg_s ^ dvs_neg_s;
            sign_r_r <= dvd_neg_s;
        end else if (step_s) begin
            if (cnt_r != {CNT_W{1'b0}}) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            rem_r <= step_rem_s;
            quo_r <= {quo_r[WIDTH-2:0], step_bit_s};
        end
    end

    // Result registers change only when a new result is produced, so they hold through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else if (accept_s && dvs_zero_s) begin
            quotient    <= {WIDTH{1'b1}};
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (fix_s) begin
            quotient    <= cond_neg(quo_r, sign_q_r);
            remainder   <= cond_neg(rem_r, sign_r_r);
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signed_div_32bit.sv
// Self-checking bench for signed_div_32bit: scoreboard of expected results built from a
// 64-bit reference division, with latency, backpressure and mid-operation reset scenarios.
module tb_signed_div_32bit;
    import div_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIV_UNSIGNED_MODE_EN
    logic         is_signed = 1'b1;
`endif

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    signed_div_32bit dut (
        .clk         (clk),
        .rst         (rst),
`ifdef DIV_UNSIGNED_MODE_EN
        .is_signed   (is_signed),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: truncating 64-bit signed division, low WIDTH bits kept.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   e;
        longint sa, sd, qq, rr;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            sa    = longint'($signed(a));
            sd    = longint'($signed(b));
            qq    = sa / sd;
            rr    = sa % sd;
            e.q   = qq[W-1:0];
            e.r   = rr[W-1:0];
            e.dz  = 1'b0;
            e.lat = W + 2;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_exp(output res_t e, output bit ok);
        ok = (exp_q.size() != 0);
        if (ok) e = exp_q.pop_front();
        else e = '0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {32'd0, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: q=%h r=%h dz=%b required zeros", quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic();
        int   lat;
        res_t e;
        bit   ok;
        send(32'd100, 32'd7);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 34) begin
            n_err++;
            $display("FAIL basic_latency: got %0d required 34", lat);
        end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
            n_err++;
            $display("FAIL basic_100_7: q=%h r=%h dz=%b required 0000000e 00000002 0", quotient, remainder, div_by_zero);
        end
        pop_exp(e, ok);
        take();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_signs();
        logic [W-1:0] ta[10];
        logic [W-1:0] tb[10];
        int   lat;
        res_t e;
        bit   ok;
        ta = '{-32'sd100, 32'd100, -32'sd100, 32'd7, 32'd123456789, -32'sd1, 32'd0,
               32'h7FFF_FFFF, $urandom, $urandom};
        tb = '{32'd7, -32'sd7, -32'sd7, -32'sd100, -32'sd1000, 32'd2, 32'd5,
               32'h8000_0000, $urandom_range(1, 1000), -$urandom_range(1, 70000)};
        for (int i = 0; i < 10; i++) begin
            send(ta[i], tb[i]);
            wait_valid(lat);
            pop_exp(e, ok);
            n_cmp++;
            if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || lat !== e.lat) begin
                n_err++;
                $display("FAIL signs_%0d: %h/%h got q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=%b lat=%0d",
                         i, ta[i], tb[i], quotient, remainder, div_by_zero, lat, e.q, e.r, e.dz, e.lat);
            end
            take();
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] ta[2];
        int   lat;
        res_t e;
        bit   ok;
        ta = '{32'd7, -32'sd5};
        for (int i = 0; i < 2; i++) begin
            send(ta[i], 32'd0);
            wait_valid(lat);
            pop_exp(e, ok);
            n_cmp++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL divzero_latency_%0d: got %0d required 1", i, lat);
            end
            n_cmp++;
            if (!ok || {quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, ta[i], 1'b1}) begin
                n_err++;
                $display("FAIL divzero_%0d: q=%h r=%h dz=%b required ffffffff %h 1", i, quotient, remainder, div_by_zero, ta[i]);
            end
            take();
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] tb[2];
        int   lat;
        res_t e;
        bit   ok;
        tb = '{32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 2; i++) begin
            send(32'h8000_0000, tb[i]);
            wait_valid(lat);
            pop_exp(e, ok);
            n_cmp++;
            if (!ok || lat !== 34 || {quotient, remainder, div_by_zero} !== {32'h8000_0000, 32'd0, 1'b0}) begin
                n_err++;
                $display("FAIL overflow_%0d: q=%h r=%h dz=%b lat=%0d required 80000000 00000000 0 lat=34",
                         i, quotient, remainder, div_by_zero, lat);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        res_t e;
        bit   ok;
        send(32'd100, 32'd7);
        wait_valid(lat);
        pop_exp(e, ok);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = 32'd1;
            @(negedge clk);
            n_cmp++;
            if (!ok || {out_valid, in_ready} !== 2'b10 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
                n_err++;
                $display("FAIL backpressure_hold_%0d: ov=%b ir=%b q=%h r=%h required 1 0 q=%h r=%h",
                         i, out_valid, in_ready, quotient, remainder, e.q, e.r);
            end
        end
        in_valid = 1'b0;
        take();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL backpressure_single_%0d: out_valid=%b in_ready=%b required 0 1", i, out_valid, in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        res_t e;
        bit   ok;
        send(32'd1000, 32'd3);
        wait_valid(lat);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || {quotient, remainder} !== {e.q, e.r}) begin
            n_err++;
            $display("FAIL b2b_first: q=%h r=%h required q=%h r=%h", quotient, remainder, e.q, e.r);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = -32'sd77;
        divisor   = 32'd5;
        exp_q.push_back(model(dividend, divisor));
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_idle_gap: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
        end
        wait_valid(lat);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || lat !== e.lat || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
            n_err++;
            $display("FAIL b2b_second: q=%h r=%h lat=%0d required q=%h r=%h lat=%0d", quotient, remainder, lat, e.q, e.r, e.lat);
        end
        take();
    endtask

    task automatic test_rst_mid();
        int   lat;
        res_t e;
        bit   ok;
        send(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_cmp++;
        if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 32'd0, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid: ov=%b ir=%b q=%h r=%h dz=%b required 0 1 zeros", out_valid, in_ready, quotient, remainder, div_by_zero);
        end
        send(32'd9, 32'd3);
        wait_valid(lat);
        pop_exp(e, ok);
        n_cmp++;
        if (!ok || lat !== 34 || {quotient, remainder, div_by_zero} !== {32'd3, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_fresh_9_3: q=%h r=%h dz=%b lat=%0d required 00000003 00000000 0 lat=34",
                     quotient, remainder, div_by_zero, lat);
        end
        take();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
